// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the core memory arbiter.
// Used by core_arb_pick and core_mem_arbiter.
package core_pkg;

  // Width of the byte-strobe field on the data port and the bus.
  localparam int ARB_STRB_W = 4;

  // Arbiter transaction FSM.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // Which pipeline stage owns the bus transaction.
  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_own_e;

endpackage

// File: rtl/core_arb_pick.sv
// core_arb_pick: combinational winner selection between fetch and data,
// plus the fairness register. The default build gives data priority with a
// starvation counter; with CORE_ARB_RR_EN defined, contended picks
// alternate strictly and the counter is not built.
module core_arb_pick
  import core_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     sample,     // arbiter is in IDLE; a win becomes a grant
  input  logic     i_req,      // raw fetch request line
  input  logic     i_ok,       // fetch is eligible this cycle
  input  logic     d_ok,       // data is eligible this cycle
  output logic     win_valid,
  output arb_own_e win_owner
);

  logic favor_i;  // a contended pick goes to fetch

  assign win_valid = i_ok | d_ok;

  // Single requester wins outright; a contended pick follows favor_i
  always_comb begin
    // NOTE: default assigned first so every path drives the output (no latch).
    win_owner = ARB_OWN_D;
    if (i_ok && (!d_ok || favor_i)) win_owner = ARB_OWN_I;
  end

  // NOTE: the register below uses non-blocking (<=) updates, and rst is
  // sampled only on the clock edge (synchronous reset).
`ifdef CORE_ARB_RR_EN
  logic last_d;        // previous contended grant went to data
  logic unused_i_req;

  assign unused_i_req = i_req;
  assign favor_i      = last_d;

  // Record the winner of every contended grant so the next one flips
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (sample && i_ok && d_ok) begin
      last_d <= (win_owner == ARB_OWN_D);
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign favor_i = (starve_cnt == LIMIT);

  // Count data grants made while fetch waits; clear once fetch is served
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (sample && win_valid) begin
      if (win_owner == ARB_OWN_I || !i_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`endif

endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares the single memory bus between instruction fetch
// and the memory-access stage, one transaction at a time
// (IDLE -> ISSUE -> WAIT -> RESP). A branch flush kills an in-flight fetch:
// the bus transaction still completes but I_DONE is withheld.
// Optional feature: define CORE_ARB_RR_EN for strict alternation on
// contended picks instead of data priority with a starvation limit.
module core_mem_arbiter
  import core_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  I_REQ,
  input  logic [31:0]           I_ADDR,
  output logic [31:0]           I_RDATA,
  output logic                  I_DONE,
  input  logic                  FLUSH,
  input  logic                  D_REQ,
  input  logic                  D_WE,
  input  logic [ARB_STRB_W-1:0] D_STRB,
  input  logic [31:0]           D_ADDR,
  input  logic [31:0]           D_WDATA,
  output logic [31:0]           D_RDATA,
  output logic                  D_DONE,
  output logic                  M_REQ,
  output logic                  M_WE,
  output logic [ARB_STRB_W-1:0] M_STRB,
  output logic [31:0]           M_ADDR,
  output logic [31:0]           M_WDATA,
  input  logic                  M_ACCEPT,
  input  logic                  M_RVALID,
  input  logic [31:0]           M_RDATA
);

  arb_state_e state;
  arb_own_e   owner;
  arb_own_e   win_owner;
  logic       win_valid;
  logic       kill;       // current fetch was flushed; suppress its I_DONE
  logic       sample;
  logic       i_ok;
  logic       d_ok;

  // A flush in the sampling cycle blocks the fetch; a requester whose DONE
  // is showing is not picked again in that cycle.
  assign sample = (state == ARB_IDLE);
  assign i_ok   = I_REQ & ~FLUSH & ~I_DONE;
  assign d_ok   = D_REQ & ~D_DONE;

  core_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk      (CLK),
    .rst      (RST),
    .sample   (sample),
    .i_req    (I_REQ),
    .i_ok     (i_ok),
    .d_ok     (d_ok),
    .win_valid(win_valid),
    .win_owner(win_owner)
  );

  // Transaction FSM with registered bus command, read data and DONE pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ARB_IDLE;
      owner   <= ARB_OWN_I;
      kill    <= 1'b0;
      M_REQ   <= 1'b0;
      M_WE    <= 1'b0;
      M_STRB  <= '0;
      M_ADDR  <= '0;
      M_WDATA <= '0;
      I_RDATA <= '0;
      D_RDATA <= '0;
      I_DONE  <= 1'b0;
      D_DONE  <= 1'b0;
    end else begin
      I_DONE <= 1'b0;
      D_DONE <= 1'b0;
      if (FLUSH && owner == ARB_OWN_I && state != ARB_IDLE) kill <= 1'b1;

      case (state)
        ARB_IDLE: begin
          if (win_valid) begin
            owner <= win_owner;
            M_REQ <= 1'b1;
            state <= ARB_ISSUE;
            if (win_owner == ARB_OWN_D) begin
              M_WE    <= D_WE;
              M_STRB  <= D_STRB;
              M_ADDR  <= D_ADDR;
              M_WDATA <= D_WDATA;
            end else begin
              M_WE    <= 1'b0;
              M_STRB  <= '0;
              M_ADDR  <= I_ADDR;
              M_WDATA <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          // The command stays up until taken, even across a flush.
          if (M_ACCEPT) begin
            M_REQ <= 1'b0;
            state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (M_RVALID) begin
            state <= ARB_RESP;
            if (owner == ARB_OWN_D) begin
              D_RDATA <= M_RDATA;
              D_DONE  <= 1'b1;
            end else if (!(kill || FLUSH)) begin
              I_RDATA <= M_RDATA;
              I_DONE  <= 1'b1;
            end
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
          kill  <= 1'b0;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: table-driven and randomized checks of the core
// memory arbiter against a transaction-level model of the pick rules.
module tb_core_mem_arbiter;
  import core_pkg::*;

  localparam int LIMIT = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        I_REQ = 1'b0;
  logic [31:0] I_ADDR = '0;
  logic [31:0] I_RDATA;
  logic        I_DONE;
  logic        FLUSH = 1'b0;
  logic        D_REQ = 1'b0;
  logic        D_WE = 1'b0;
  logic [3:0]  D_STRB = '0;
  logic [31:0] D_ADDR = '0;
  logic [31:0] D_WDATA = '0;
  logic [31:0] D_RDATA;
  logic        D_DONE;
  logic        M_REQ;
  logic        M_WE;
  logic [3:0]  M_STRB;
  logic [31:0] M_ADDR;
  logic [31:0] M_WDATA;
  logic        M_ACCEPT = 1'b0;
  logic        M_RVALID = 1'b0;
  logic [31:0] M_RDATA = '0;

  core_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_DONE(I_DONE),
    .FLUSH(FLUSH),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_STRB(D_STRB), .D_ADDR(D_ADDR),
    .D_WDATA(D_WDATA), .D_RDATA(D_RDATA), .D_DONE(D_DONE),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_STRB(M_STRB), .M_ADDR(M_ADDR),
    .M_WDATA(M_WDATA), .M_ACCEPT(M_ACCEPT), .M_RVALID(M_RVALID),
    .M_RDATA(M_RDATA)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  logic        i_pend, d_pend;

  typedef struct {
    logic       i;
    logic       d;
    logic       we;
    logic [3:0] strb;
    int         acc;
    int         rv;
    logic [31:0] rdata;
    arb_own_e   exp_pri;
    arb_own_e   exp_rr;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [68:0] cmd_of(input arb_own_e who, input logic we, input logic [3:0] strb,
                                         input logic [31:0] addr, input logic [31:0] wdata);
    if (who == ARB_OWN_I) return {we, 4'h0, addr, 32'h0};
    return {we, strb, addr, wdata};
  endfunction

  // Requests must already be driven during an IDLE cycle. Runs one bus
  // transaction with the given stall lengths and checks command, timing,
  // DONE pulse and read data for the expected owner.
  task automatic run_txn(input arb_own_e exp, input int acc, input int rv,
                         input logic [31:0] rdata, input string tag);
    int n;
    logic [68:0] exp_cmd;
    n = 0;
    do begin
      tick();
      n++;
    end while (!M_REQ && n < 6);
    check({tag, " m_req latency"}, n, 1);
    exp_cmd = (exp == ARB_OWN_I) ? cmd_of(ARB_OWN_I, 1'b0, 4'h0, I_ADDR, 32'h0)
                                 : cmd_of(ARB_OWN_D, D_WE, D_STRB, D_ADDR, D_WDATA);
    check({tag, " cmd"}, cmd_of(exp, M_WE, M_STRB, M_ADDR, M_WDATA), exp_cmd);
    for (int k = 0; k < acc; k++) begin
      // Stray response strobes while unaccepted must be ignored.
      M_RVALID = 1'b1;
      M_RDATA  = $urandom;
      tick();
      check({tag, " stall m_req"}, M_REQ, 1'b1);
      check({tag, " stall cmd"}, cmd_of(exp, M_WE, M_STRB, M_ADDR, M_WDATA), exp_cmd);
    end
    M_RVALID = 1'b0;
    M_ACCEPT = 1'b1;
    tick();
    M_ACCEPT = 1'b0;
    check({tag, " m_req drop"}, M_REQ, 1'b0);
    for (int k = 0; k < rv; k++) begin
      tick();
      check({tag, " early done"}, {I_DONE, D_DONE}, 2'b00);
    end
    M_RVALID = 1'b1;
    M_RDATA  = rdata;
    tick();
    M_RVALID = 1'b0;
    M_RDATA  = $urandom;
    if (exp == ARB_OWN_I) exp_i_rdata = rdata;
    else                  exp_d_rdata = rdata;
    check({tag, " done"}, {I_DONE, D_DONE}, (exp == ARB_OWN_I) ? 2'b10 : 2'b01);
    check({tag, " rdata"}, {I_RDATA, D_RDATA}, {exp_i_rdata, exp_d_rdata});
    tick();
    check({tag, " done width"}, {I_DONE, D_DONE}, 2'b00);
  endtask

  initial begin
    arb_own_e exp;
    arb_own_e win;
    int       consec;
    logic     rr_last_d;

    //            i     d     we    strb  acc rv rdata          pri        rr
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'hF, 0, 0, 32'h600D_0000, ARB_OWN_D, ARB_OWN_D};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'hF, 1, 0, 32'h600D_0001, ARB_OWN_D, ARB_OWN_I};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'hF, 0, 2, 32'h600D_0002, ARB_OWN_I, ARB_OWN_D};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 4'hF, 0, 0, 32'h600D_0003, ARB_OWN_D, ARB_OWN_I};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'hF, 2, 1, 32'h600D_0004, ARB_OWN_D, ARB_OWN_D};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'hF, 0, 0, 32'h600D_0005, ARB_OWN_I, ARB_OWN_I};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 4'hC, 0, 0, 32'h600D_0006, ARB_OWN_D, ARB_OWN_D};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1, 1, 32'h600D_0007, ARB_OWN_I, ARB_OWN_I};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'h1, 0, 0, 32'h600D_0008, ARB_OWN_D, ARB_OWN_D};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'hF, 0, 0, 32'h600D_0009, ARB_OWN_D, ARB_OWN_I};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4'hF, 0, 0, 32'h600D_000A, ARB_OWN_I, ARB_OWN_D};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 4'h3, 0, 0, 32'h600D_000B, ARB_OWN_D, ARB_OWN_I};

    // Reset state
    repeat (3) tick();
    check("reset cmd/done", {M_REQ, M_WE, M_STRB, M_ADDR, M_WDATA, I_DONE, D_DONE}, '0);
    check("reset rdata", {I_RDATA, D_RDATA}, '0);
    RST = 1'b0;
    tick();

    // Zero-wait fetch at address 0
    I_REQ  = 1'b1;
    I_ADDR = 32'h0;
    run_txn(ARB_OWN_I, 0, 0, 32'h3E80_0093, "fetch0");
    I_REQ = 1'b0;

    // Grant order under contention, then single requesters
    i_pend = 1'b0;
    d_pend = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (tbl[k].i && !i_pend) begin
        i_pend = 1'b1;
        I_ADDR = 32'h1000 + 32'(k * 4);
      end
      if (tbl[k].d && !d_pend) begin
        d_pend  = 1'b1;
        D_WE    = tbl[k].we;
        D_STRB  = tbl[k].strb;
        D_ADDR  = 32'h100;
        D_WDATA = 32'hA500_0000 + 32'(k);
      end
      I_REQ = i_pend;
      D_REQ = d_pend;
`ifdef CORE_ARB_RR_EN
      exp = tbl[k].exp_rr;
`else
      exp = tbl[k].exp_pri;
`endif
      run_txn(exp, tbl[k].acc, tbl[k].rv, tbl[k].rdata, $sformatf("vec%0d", k));
      if (exp == ARB_OWN_I) i_pend = 1'b0;
      else                  d_pend = 1'b0;
      I_REQ = i_pend;
      D_REQ = d_pend;
    end
    if (i_pend) begin
      run_txn(ARB_OWN_I, 0, 0, 32'h0DD0_0001, "drain_i");
      i_pend = 1'b0;
      I_REQ  = 1'b0;
    end
    if (d_pend) begin
      run_txn(ARB_OWN_D, 0, 0, 32'h0DD0_0002, "drain_d");
      d_pend = 1'b0;
      D_REQ  = 1'b0;
    end

    // Store with a stalled accept
    D_REQ   = 1'b1;
    D_WE    = 1'b1;
    D_STRB  = 4'b0011;
    D_ADDR  = 32'h200;
    D_WDATA = 32'hDEAD_BEEF;
    run_txn(ARB_OWN_D, 3, 0, 32'h0000_5A5A, "store");
    D_REQ = 1'b0;

    // Flush in IDLE blocks the fetch for that cycle
    I_REQ  = 1'b1;
    I_ADDR = 32'h40;
    FLUSH  = 1'b1;
    tick();
    check("flush idle no grant", M_REQ, 1'b0);
    FLUSH = 1'b0;
    run_txn(ARB_OWN_I, 0, 0, 32'h1234_0040, "after_flush");
    I_REQ = 1'b0;

    // Flush while the fetch waits for its response
    I_REQ  = 1'b1;
    I_ADDR = 32'h80;
    tick();
    check("kill m_req", M_REQ, 1'b1);
    M_ACCEPT = 1'b1;
    tick();
    M_ACCEPT = 1'b0;
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    I_REQ = 1'b0;
    tick();
    M_RVALID = 1'b1;
    M_RDATA  = 32'hBAD0_0080;
    tick();
    M_RVALID = 1'b0;
    check("kill no done", {I_DONE, D_DONE}, 2'b00);
    check("kill rdata held", I_RDATA, exp_i_rdata);
    tick();
    check("kill idle no done", {I_DONE, D_DONE}, 2'b00);
    D_REQ = 1'b1;
    D_WE  = 1'b0;
    D_ADDR = 32'h104;
    run_txn(ARB_OWN_D, 0, 0, 32'h7777_0104, "after_kill");
    D_REQ = 1'b0;

    // Reset in WAIT abandons the fetch
    I_REQ  = 1'b1;
    I_ADDR = 32'h300;
    tick();
    M_ACCEPT = 1'b1;
    tick();
    M_ACCEPT = 1'b0;
    RST = 1'b1;
    tick();
    RST   = 1'b0;
    I_REQ = 1'b0;
    check("rst mid cmd/done", {M_REQ, M_WE, M_STRB, M_ADDR, M_WDATA, I_DONE, D_DONE}, '0);
    check("rst mid rdata", {I_RDATA, D_RDATA}, '0);
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    M_RVALID = 1'b1;
    M_RDATA  = 32'hFEED_0300;
    tick();
    M_RVALID = 1'b0;
    check("late rvalid no done", {I_DONE, D_DONE}, 2'b00);
    tick();
    check("late rvalid idle", {M_REQ, I_DONE, D_DONE}, 3'b000);
    D_REQ   = 1'b1;
    D_WE    = 1'b1;
    D_STRB  = 4'hF;
    D_ADDR  = 32'h400;
    D_WDATA = 32'h0BAD_CAFE;
    run_txn(ARB_OWN_D, 0, 0, 32'h1, "post_rst");
    D_REQ = 1'b0;

    // Randomized traffic against the pick-rule model
    consec    = 0;
    rr_last_d = 1'b0;
    i_pend    = 1'b0;
    d_pend    = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (!i_pend && $urandom_range(0, 99) < 60) begin
        i_pend = 1'b1;
        I_ADDR = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(0, 99) < 60) begin
        d_pend  = 1'b1;
        D_WE    = 1'($urandom_range(0, 1));
        D_STRB  = 4'($urandom_range(0, 15));
        D_ADDR  = $urandom;
        D_WDATA = $urandom;
      end
      I_REQ = i_pend;
      D_REQ = d_pend;
      if (!i_pend && !d_pend) begin
        tick();
        check("rand idle", M_REQ, 1'b0);
        continue;
      end
      if (i_pend && d_pend) begin
`ifdef CORE_ARB_RR_EN
        win = rr_last_d ? ARB_OWN_I : ARB_OWN_D;
        rr_last_d = (win == ARB_OWN_D);
`else
        win = (consec >= LIMIT) ? ARB_OWN_I : ARB_OWN_D;
`endif
      end else begin
        win = i_pend ? ARB_OWN_I : ARB_OWN_D;
      end
      // Data wins in a row over a waiting fetch, capped at the limit.
      if (win == ARB_OWN_I || !i_pend) consec = 0;
      else if (consec < LIMIT)         consec = consec + 1;
      run_txn(win, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, $sformatf("rand%0d", t));
      if (win == ARB_OWN_I) i_pend = 1'b0;
      else                  d_pend = 1'b0;
      I_REQ = i_pend;
      D_REQ = d_pend;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares the single memory bus between the instruction-fetch stage and the memory-access stage of the pipelined RISC-V core. It serializes one transaction at a time, picks a winner when both stages request, and returns read data and completion to the owner. It cancels an in-flight fetch on a branch flush. It sits between the core's fetch/memrd stages and the memory bus bridge.

## Interface
- STARVE_LIMIT, 4: maximum consecutive data grants while a fetch is pending before a fetch must win (1..15).
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- I_REQ  in  1  fetch request; held until I_DONE or FLUSH.
- I_ADDR  in  32  fetch address; stable while I_REQ.
- I_RDATA  out  32  fetched instruction; valid with I_DONE.
- I_DONE  out  1  one-cycle fetch completion pulse.
- FLUSH  in  1  branch/jump flush; cancels the current fetch.
- D_REQ  in  1  data request; held until D_DONE.
- D_WE  in  1  1 = store, 0 = load.
- D_STRB  in  4  byte strobes for stores.
- D_ADDR  in  32  data address.
- D_WDATA  in  32  store data.
- D_RDATA  out  32  load data; valid with D_DONE.
- D_DONE  out  1  one-cycle data completion pulse; also issued for stores.
- M_REQ  out  1  bus request valid.
- M_WE / M_STRB / M_ADDR / M_WDATA  out  1/4/32/32  registered copy of the winner's command.
- M_ACCEPT  in  1  bus accepts the command when M_REQ && M_ACCEPT.
- M_RVALID  in  1  one-cycle response or write completion.
- M_RDATA  in  32  read data with M_RVALID.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: sample the requests. If any requester wins, latch its command into the M_* registers and record the owner, then go to ISSUE. With no request, stay in IDLE.
- Pick rule:
  - Only one requester: it wins.
  - Both requesting: data wins, unless the starvation counter equals STARVE_LIMIT; then fetch wins.
- Starvation counter:
  - Increments on each data grant made while I_REQ is high.
  - Clears on any fetch grant, and when I_REQ is low at a grant.
  - Saturates at STARVE_LIMIT.
- ISSUE: M_REQ = 1 and the command is held stable until M_ACCEPT. Then go to WAIT. M_REQ is never retracted before acceptance, even on FLUSH.
- WAIT: on M_RVALID, register M_RDATA into the owner's RDATA and go to RESP.
- RESP: the owner's DONE = 1 for exactly one cycle, then go to IDLE. A requester whose DONE is high is ignored by the pick in that cycle's sampling. The requester drops REQ or presents a new command next cycle.
- FLUSH:
  - In IDLE: a concurrent I_REQ is not granted that cycle.
  - While the owner is fetch in ISSUE/WAIT/RESP: set the kill flag. The transaction completes on the bus, but I_DONE is suppressed, and the kill flag clears on return to IDLE.
  - No effect on data transactions.
- RDATA outputs keep their last value outside DONE cycles.

## Timing
- Reset values: M_REQ, M_WE, I_DONE, D_DONE = 0; M_STRB = 0; M_ADDR, M_WDATA, I_RDATA, D_RDATA = 0; state = IDLE; counter = 0; kill flag = 0.
- RST mid-transaction abandons it without a DONE pulse. The bus bridge is reset on the same RST.
- Minimum latency from REQ (cycle 0) with M_ACCEPT and M_RVALID both zero-wait:
  - M_REQ in cycle 1, M_RVALID in cycle 2, DONE in cycle 3.
  - IDLE in cycle 4; the next M_REQ is in cycle 5.
- Sustained throughput: one transaction per 4 cycles.
- M_RVALID outside WAIT is ignored.

## Configuration
- CORE_ARB_RR_EN defined: when both request, the pick alternates strictly. The winner is the requester that did not win the previous contended grant, and data wins the first one after reset. The starvation counter and STARVE_LIMIT are unused.
- CORE_ARB_RR_EN undefined: data priority with the starvation counter, as described in Operation.

## Structure
- core_pkg holds:
  - FSM state encoding (ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP).
  - Owner IDs (ARB_OWN_I, ARB_OWN_D).
  - Strobe width constant.
- One sub-module: core_arb_pick, the combinational winner selection plus the starvation counter / round-robin flag register.

## Test plan
- I_REQ only, addr 0x0000_0000, zero-wait bus returning 0x3E800093 → M_REQ in cycle 1 with M_ADDR = 0; I_DONE in cycle 3 with I_RDATA = 0x3E800093.
- I_REQ and D_REQ (load at 0x100) raised together, STARVE_LIMIT = 2, both re-requested after each DONE → grant order D, D, I, D, D, I.
- Store with D_STRB = 0b0011, WDATA = 0xDEADBEEF, M_ACCEPT delayed 3 cycles → M_* stable across the stall; D_DONE one cycle after M_RVALID.
- Fetch in WAIT, FLUSH pulse, M_RVALID 2 cycles later → no I_DONE, and the arbiter is back in IDLE one cycle after RESP.
- RST asserted in WAIT → the next cycle has every output 0 and state IDLE; a late M_RVALID produces no DONE.
- With CORE_ARB_RR_EN and both requesting continuously → grants alternate D, I, D, I.
